// File: rtl/unpk_pkg.sv
// Shared types and symbol-extraction helpers for the word unpacker.
// Holds word/symbol typedefs, FSM state enum and symbol counts.
package unpk_pkg;

  typedef logic [1:0]  sym2_t;
  typedef logic [3:0]  sym4_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int N_SYM2 = 16;
  localparam int N_SYM4 = 8;

  function automatic sym2_t get_sym2(
    input word_t       w,
    input logic [3:0]  f
  );
    return w[{f, 1'b0} +: 2];
  endfunction

  function automatic sym4_t get_sym4(
    input word_t       w,
    input logic [2:0]  f
  );
    return w[{f, 2'b00} +: 4];
  endfunction

  function automatic sym4_t sext2(input sym2_t s);
    return {{2{s[1]}}, s};
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Splits 32-bit words into 2-bit (sign-extended) or 4-bit symbols.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_mode, out_valid/out_ready/out_sym/out_idx/out_last.
module word_unpacker
  import unpk_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_sym,
  output logic [3:0]  out_idx,
  output logic        out_last
);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  word_t      buf_q, buf_d;
  logic       mode_q, mode_d;

  logic       out_hs;
  logic       in_hs;
  logic [3:0] field;

  always_comb begin
    field = idx_q;
    // MSB-first reads fields from the top of the word down.
    if (LSB_FIRST == 1'b0) begin
      field = mode_q ? {1'b0, ~idx_q[2:0]} : ~idx_q;
    end
  end

  always_comb begin
    out_valid = (state_q == EMIT);
    out_idx   = idx_q;
    out_last  = out_valid &&
                (mode_q ? (idx_q == 4'(N_SYM4 - 1))
                        : (idx_q == 4'(N_SYM2 - 1)));
    out_sym   = mode_q ? get_sym4(buf_q, field[2:0])
                       : sext2(get_sym2(buf_q, field));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    mode_d   = mode_q;
    out_hs   = out_valid && out_ready;
    // A word slot frees up either when empty or as the last symbol leaves.
    in_ready = (state_q == IDLE) || (out_hs && out_last);
    in_hs    = in_valid && in_ready;
    if (in_hs) begin
      buf_d   = in_data;
      mode_d  = in_mode;
      idx_d   = 4'd0;
      state_d = EMIT;
    end else if (out_hs) begin
      // idx parks on the last symbol; only a new word resets it.
      if (out_last) state_d = IDLE;
      else          idx_d   = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      buf_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: LSB-first and MSB-first builds
// driven in parallel against a queue-based symbol model.
module tb_word_unpacker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_ready;

  logic        ir_l, ov_l, last_l;
  logic [3:0]  sym_l, idx_l;
  logic        ir_m, ov_m, last_m;
  logic [3:0]  sym_m, idx_m;

  int total = 0;
  int bad   = 0;

  word_unpacker #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_l),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(ov_l), .out_ready(out_ready),
    .out_sym(sym_l), .out_idx(idx_l), .out_last(last_l)
  );

  word_unpacker #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_m),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(ov_m), .out_ready(out_ready),
    .out_sym(sym_m), .out_idx(idx_m), .out_last(last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s_l;
    logic [3:0] s_m;
    logic [3:0] idx;
    logic       last;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic [31:0] data;
    logic        mode;
    int          n;
    logic [3:0]  l_first;
    logic [3:0]  l_last;
    logic [3:0]  m_first;
    logic [3:0]  m_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] field_sym(input logic [31:0] w,
                                           input logic m, input int f);
    int v;
    if (m) return 4'((w >> (4 * f)) & 15);
    v = int'((w >> (2 * f)) & 3);
    // two-bit two's complement: 2 -> -2, 3 -> -1 in four bits
    if (v >= 2) v = v + 12;
    return 4'(v);
  endfunction

  task automatic push_word(input logic [31:0] w, input logic m);
    int n;
    ent_t e;
    n = m ? 8 : 16;
    for (int i = 0; i < n; i++) begin
      e.s_l  = field_sym(w, m, i);
      e.s_m  = field_sym(w, m, n - 1 - i);
      e.idx  = 4'(i);
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  function automatic logic exp_ready();
    return (q.size() == 0) || (q.size() == 1 && out_ready);
  endfunction

  task automatic check_model();
    logic ev;
    ev = (q.size() > 0);
    chk("valid_l", ov_l, ev);
    chk("valid_m", ov_m, ev);
    chk("ready_l", ir_l, exp_ready());
    chk("ready_m", ir_m, exp_ready());
    if (ev) begin
      chk("sym_l",  sym_l,  q[0].s_l);
      chk("sym_m",  sym_m,  q[0].s_m);
      chk("idx_l",  idx_l,  q[0].idx);
      chk("idx_m",  idx_m,  q[0].idx);
      chk("last_l", last_l, q[0].last);
      chk("last_m", last_m, q[0].last);
    end
  endtask

  // Inputs are driven just after the falling edge; check, then clock.
  task automatic tick();
    logic acc, pop;
    #1;
    check_model();
    acc = in_valid && exp_ready();
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) push_word(in_data, in_mode);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  vec_t vt[5];
  int   ov_cnt, ir_cnt, seen;

  initial begin
    vt[0] = '{32'h0000_0003, 1'b0, 16, 4'hF, 4'h0, 4'h0, 4'hF};
    vt[1] = '{32'h7654_3210, 1'b1,  8, 4'h0, 4'h7, 4'h7, 4'h0};
    vt[2] = '{32'h8000_0001, 1'b0, 16, 4'h1, 4'hE, 4'hE, 4'h1};
    vt[3] = '{32'hA5A5_A5A5, 1'b1,  8, 4'h5, 4'hA, 4'hA, 4'h5};
    vt[4] = '{32'h4000_0002, 1'b0, 16, 4'hE, 4'h1, 4'h1, 4'hE};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {ov_l, ov_m}, 2'b00);
    chk("rst_sym",   {sym_l, sym_m}, 8'h00);
    chk("rst_idx",   {idx_l, idx_m}, 8'h00);
    chk("rst_last",  {last_l, last_m}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {ir_l, ir_m}, 2'b11);
    @(negedge clk);

    // directed table: one isolated word each, no stalls
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1; in_data = vt[v].data; in_mode = vt[v].mode;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_mode  = ~vt[v].mode;
      in_data  = ~vt[v].data;
      for (int k = 0; k < vt[v].n; k++) begin
        #1;
        if (k == 0) begin
          chk("tbl_first_l", sym_l, vt[v].l_first);
          chk("tbl_first_m", sym_m, vt[v].m_first);
        end
        if (k == vt[v].n - 1) begin
          chk("tbl_last_l", sym_l, vt[v].l_last);
          chk("tbl_last_m", sym_m, vt[v].m_last);
          chk("tbl_lastflag", {last_l, last_m}, 2'b11);
        end else begin
          chk("tbl_notlast", {last_l, last_m}, 2'b00);
        end
        tick();
      end
      #1;
      chk("tbl_idle", {ov_l, ov_m}, 2'b00);
      @(negedge clk);
    end

    // back-to-back words with in_valid held high
    in_valid = 1'b1; in_mode = 1'b0; in_data = $urandom;
    out_ready = 1'b1;
    tick();
    ov_cnt = 0; ir_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      in_data = $urandom;
      #1;
      if (ov_l) ov_cnt++;
      if (ir_l) ir_cnt++;
      tick();
    end
    chk("b2b_valid_cycles", ov_cnt, 32);
    chk("b2b_ready_pulses", ir_cnt, 2);
    drain();

    // mode toggled while a 4-bit word is held
    in_valid = 1'b1; in_mode = 1'b1; in_data = 32'hFEDC_BA98;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      in_mode = ~in_mode;
      out_ready = c[0];
      #1;
      if (ov_l && out_ready) seen++;
      tick();
    end
    chk("toggle_count", seen, 8);
    drain();

    // reset in the middle of a word at idx5
    in_valid = 1'b1; in_mode = 1'b0; in_data = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("pre_rst_idx", idx_l, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("async_valid", {ov_l, ov_m}, 2'b00);
    chk("async_sym",   {sym_l, sym_m}, 8'h00);
    chk("async_idx",   {idx_l, idx_m}, 8'h00);
    chk("async_last",  {last_l, last_m}, 2'b00);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {ir_l, ir_m}, 2'b11);
    @(negedge clk);
    for (int c = 0; c < 20; c++) tick();

    // random traffic with stalls and mode changes
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_data   = $urandom;
      in_mode   = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = symbol 0 taken from word bits [low], 0 = from word bits [high].
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data/in_mode valid.
REQ-005 SHALL have port in_ready  output  1  unpacker accepts a word this cycle.
REQ-006 SHALL have port in_data  input  32  packed word (unpk_pkg::word_t).
REQ-007 SHALL have port in_mode  input  1  0 = 2-bit symbols (16/word), 1 = 4-bit symbols (8/word).
REQ-008 SHALL have port out_valid  output  1  out_sym valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts symbol.
REQ-010 SHALL have port out_sym  output  4  symbol (unpk_pkg::sym4_t); 2-bit symbols sign-extended.
REQ-011 SHALL have port out_idx  output  4  symbol index within current word.
REQ-012 SHALL have port out_last  output  1  high with last symbol of word.

Function
REQ-013 SHALL implement states IDLE (no word held) and EMIT (word held, presenting symbols).
REQ-014 SHALL accept a word when in_valid && in_ready; in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
REQ-015 SHALL, on accept, latch in_data and in_mode into a one-word buffer, set idx=0, enter EMIT; out_valid asserts the next cycle (latency 1).
REQ-016 SHALL, in EMIT, drive out_sym from buffer field idx: mode0 bits [2*idx+1:2*idx] sign-extended, mode1 bits [4*idx+3:4*idx] (LSB_FIRST=1); field index mirrored (15-idx / 7-idx) when LSB_FIRST=0.
REQ-017 SHALL hold out_sym/out_idx/out_last stable while out_valid && !out_ready.
REQ-018 SHALL advance idx by 1 on each out handshake; out_last = (idx==15) in mode0, (idx==7) in mode1.
REQ-019 SHALL, on last-symbol handshake with in_valid high, accept the next word same cycle and present its symbol 0 next cycle (zero-bubble back-to-back).
REQ-020 SHALL, on last-symbol handshake with in_valid low, return to IDLE, out_valid=0.
REQ-021 SHALL ignore in_mode/in_data changes while a word is held; mode is per-word.
REQ-022 SHALL never wrap idx past the last symbol; idx resets to 0 only on a new word accept.

Reset
REQ-023 SHALL on rst_n low asynchronously force state=IDLE, idx=0, buffer=0, mode=0, out_valid=0, out_sym=0, out_idx=0, out_last=0.
REQ-024 SHALL discard any partially emitted word on reset; no symbols of it appear after release.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset release.

Structure
REQ-026 SHALL place in package unpk_pkg: typedef logic [1:0] sym2_t, logic [3:0] sym4_t, logic [31:0] word_t, enum state_t {IDLE, EMIT}, constants N_SYM2=16, N_SYM4=8.
REQ-027 SHALL extract symbols via automatic functions declared with package typedef return types (sym2_t get_sym2(...), sym4_t get_sym4(...), sym4_t sext2(...)).
REQ-028 SHALL contain no sub-modules; extraction is the functions above, FSM/counter in one module.

Verification
REQ-029 SHALL cover mode0, LSB_FIRST=1, word 32'h0000_0003, out_ready=1 -> 16 symbols: idx0 = 4'hF, idx1..15 = 4'h0, out_last only at idx15.
REQ-030 SHALL cover mode1, word 32'h7654_3210 -> symbols 0,1,2,...,7, out_last at idx7; LSB_FIRST=0 build -> 7,6,...,0.
REQ-031 SHALL cover back-to-back words with in_valid held high -> 32 consecutive out_valid cycles, no bubble, in_ready pulses only at last handshakes.
REQ-032 SHALL cover random out_ready stalls -> out_sym/out_idx stable during stall, no symbol lost or duplicated vs scoreboard.
REQ-033 SHALL cover in_mode toggled mid-word -> current word keeps latched mode; new mode applies only to next word.
REQ-034 SHALL cover rst_n asserted at idx5 of a word -> outputs zero immediately (async), after release in_ready=1, no residual symbols.
